uart_cmd_decoder: RTL and testbench

Byte-stream command responder between `uart_rx` and the SDRAM controller's user port. It consumes received bytes (`po_data`/`po_flag` of `uart_rx`), parses fixed-format write/read frames, issues one SDRAM command per frame over a valid/ready handshake, and returns a one-byte response (write ack or read data) as a `tx_flag` pulse for `uart_tx`. It replaces the raw rx→tx echo path once the SDRAM port is wired in.

---
 rtl/uart_cmd_pkg.sv | 23 ++
 rtl/uart_gap_timer.sv | 28 ++
 rtl/uart_cmd_decoder.sv | 154 +++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, response byte and FSM encoding for the UART command decoder.
// Imported by the decoder top and its gap timer.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR    = 8'h01;
  localparam logic [7:0] OP_RD    = 8'h02;
  localparam logic [7:0] ACK_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPC     = 3'd1,
    S_ADDR_H  = 3'd2,
    S_ADDR_L  = 3'd3,
    S_DATA    = 3'd4,
    S_ISSUE   = 3'd5,
    S_WAIT_RD = 3'd6
  } state_t;

  function automatic logic in_frame(state_t s);
    return (s inside {S_OPC, S_ADDR_H, S_ADDR_L, S_DATA});
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: saturates at TIMEOUT_CYC and flags expiry.
// Held at zero while disabled or when cleared.
module uart_gap_timer #(
  parameter int unsigned TIMEOUT_CYC = 104160,
  localparam int W = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [W-1:0] r_cnt;

  assign expired = (r_cnt == W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || !en) begin
      r_cnt <= '0;
    end else if (!expired) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses UART write/read frames, issues one SDRAM command per frame
// and answers with a single response byte for uart_tx.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  HEADER      = 8'h55,
  parameter int          ADDR_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 104160
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_flag,
  output logic              cmd_valid,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_wdata,
  input  logic              cmd_ready,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  output logic              tx_flag,
  output logic [7:0]        tx_data,
  output logic              err_flag
);

  state_t      r_state, w_state_n;
  logic        r_op_wr, w_op_wr_n;
  logic [15:0] r_addr, w_addr_n;
  logic [7:0]  r_wdata, w_wdata_n;
  logic        r_cmd_valid, w_cmd_valid_n;
  logic        r_tx_flag, w_tx_flag_n;
  logic [7:0]  r_tx_data, w_tx_data_n;
  logic        r_err, w_err_n;
  logic        w_in_frame;
  logic        w_expired;
  logic        w_timeout;

  assign w_in_frame = in_frame(r_state);
  // A byte landing on the expiry edge wins over the timeout
  assign w_timeout  = w_expired && w_in_frame && !rx_flag;

  uart_gap_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_gap_timer (
    .clk     (sclk),
    .rst_n   (s_rst_n),
    .clr     (rx_flag),
    .en      (w_in_frame),
    .expired (w_expired)
  );

  always_comb begin
    w_state_n   = r_state;
    w_op_wr_n   = r_op_wr;
    w_addr_n    = r_addr;
    w_wdata_n   = r_wdata;
    w_tx_flag_n = 1'b0;
    w_tx_data_n = r_tx_data;
    w_err_n     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (rx_flag && rx_data == HEADER) w_state_n = S_OPC;
      end
      S_OPC: begin
        if (rx_flag) begin
          if (rx_data == OP_WR || rx_data == OP_RD) begin
            w_op_wr_n = (rx_data == OP_WR);
            w_state_n = S_ADDR_H;
          end else begin
            w_err_n   = 1'b1;
            w_state_n = S_IDLE;
          end
        end
      end
      S_ADDR_H: begin
        if (rx_flag) begin
          w_addr_n[15:8] = rx_data;
          w_state_n      = S_ADDR_L;
        end
      end
      S_ADDR_L: begin
        if (rx_flag) begin
          w_addr_n[7:0] = rx_data;
          w_state_n     = r_op_wr ? S_DATA : S_ISSUE;
        end
      end
      S_DATA: begin
        if (rx_flag) begin
          w_wdata_n = rx_data;
          w_state_n = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_cmd_valid && cmd_ready) begin
          if (r_op_wr) begin
            w_tx_flag_n = 1'b1;
            w_tx_data_n = ACK_BYTE;
            w_state_n   = S_IDLE;
          end else begin
            w_state_n = S_WAIT_RD;
          end
        end
        // A response pulse takes the cycle; a stray byte is still dropped
        if (rx_flag && !w_tx_flag_n) w_err_n = 1'b1;
      end
      S_WAIT_RD: begin
        if (rd_valid) begin
          w_tx_flag_n = 1'b1;
          w_tx_data_n = rd_data;
          w_state_n   = S_IDLE;
        end else if (rx_flag) begin
          w_err_n = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (w_timeout) begin
      w_err_n   = 1'b1;
      w_state_n = S_IDLE;
    end
    w_cmd_valid_n = (w_state_n == S_ISSUE);
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state     <= S_IDLE;
      r_op_wr     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cmd_valid <= 1'b0;
      r_tx_flag   <= 1'b0;
      r_tx_data   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_op_wr     <= w_op_wr_n;
      r_addr      <= w_addr_n;
      r_wdata     <= w_wdata_n;
      r_cmd_valid <= w_cmd_valid_n;
      r_tx_flag   <= w_tx_flag_n;
      r_tx_data   <= w_tx_data_n;
      r_err       <= w_err_n;
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_wr    = r_op_wr;
  assign cmd_addr  = ADDR_W'(r_addr);
  assign cmd_wdata = r_wdata;
  assign tx_flag   = r_tx_flag;
  assign tx_data   = r_tx_data;
  assign err_flag  = r_err;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: frame table plus hand-written timing,
// timeout, WAIT_RD intrusion and mid-command reset sequences.
module tb_uart_cmd_decoder;

  localparam int T = 40;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic [7:0]  rx_data;
  logic        rx_flag;
  logic        cmd_valid;
  logic        cmd_wr;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        cmd_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        tx_flag;
  logic [7:0]  tx_data;
  logic        err_flag;

  always #5 sclk = ~sclk;

  uart_cmd_decoder #(
    .HEADER      (8'h55),
    .ADDR_W      (16),
    .TIMEOUT_CYC (T)
  ) dut (
    .sclk      (sclk),
    .s_rst_n   (s_rst_n),
    .rx_data   (rx_data),
    .rx_flag   (rx_flag),
    .cmd_valid (cmd_valid),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_ready (cmd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .tx_flag   (tx_flag),
    .tx_data   (tx_data),
    .err_flag  (err_flag)
  );

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
  } cmd_t;

  typedef struct {
    logic [39:0] bytes;
    int          n;
    int          errs;
    bit          has;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  wd;
  } vec_t;

  cmd_t       cmd_q[$];
  logic [7:0] tx_q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         err_cnt = 0;
  bit         auto_resp = 0;
  vec_t       vt[8];

  function automatic void check(string nm, logic [31:0] act, logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, want);
    end
  endfunction

  function automatic vec_t mk(logic [39:0] b, int n, int e, bit h,
                              bit w, logic [15:0] a, logic [7:0] d);
    vec_t v;
    v.bytes = b; v.n = n; v.errs = e; v.has = h;
    v.wr = w; v.addr = a; v.wd = d;
    return v;
  endfunction

  function automatic logic [7:0] rd_model(logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  task automatic idle(int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    rx_data = b;
    rx_flag = 1'b1;
    @(posedge sclk);
    #1;
    rx_flag = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((tx_q.size() != 0 || cmd_q.size() != 0) && k < 300) begin
      @(posedge sclk);
      k++;
    end
    #1;
    check("drain", tx_q.size() + cmd_q.size(), 0);
  endtask

  task automatic check_zero(string nm);
    check({nm, "_valid"}, cmd_valid, 0);
    check({nm, "_wr"}, cmd_wr, 0);
    check({nm, "_addr"}, cmd_addr, 0);
    check({nm, "_wdata"}, cmd_wdata, 0);
    check({nm, "_txf"}, tx_flag, 0);
    check({nm, "_txd"}, tx_data, 0);
    check({nm, "_err"}, err_flag, 0);
  endtask

  // Output monitor / scoreboard
  initial begin
    logic [7:0] want;
    cmd_t       c, prev;
    bit         pv;
    pv = 0;
    prev = '0;
    forever begin
      @(negedge sclk);
      if (tx_flag) begin
        if (tx_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_unexpected: got %0h, required no response", tx_data);
        end else begin
          want = tx_q.pop_front();
          check("tx_data", tx_data, want);
        end
        check("tx_err_overlap", err_flag, 0);
      end
      if (err_flag) err_cnt++;
      if (cmd_valid && cmd_ready) begin
        if (cmd_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL cmd_unexpected: got addr %0h, required no command", cmd_addr);
        end else begin
          c = cmd_q.pop_front();
          check("cmd_wr", cmd_wr, c.wr);
          check("cmd_addr", cmd_addr, c.addr);
          if (c.wr) check("cmd_wdata", cmd_wdata, c.wd);
        end
      end
      if (cmd_valid && pv)
        check("cmd_stable", {cmd_wr, cmd_addr, cmd_wdata}, prev);
      pv = cmd_valid && !cmd_ready;
      prev = {cmd_wr, cmd_addr, cmd_wdata};
    end
  end

  // Automatic SDRAM-side responder
  initial begin
    bit          acc, accwr;
    logic [15:0] acca;
    int          rd_cnt;
    logic [7:0]  rd_pend;
    rd_cnt = 0;
    rd_pend = '0;
    forever begin
      @(posedge sclk);
      acc = cmd_valid && cmd_ready;
      accwr = cmd_wr;
      acca = cmd_addr;
      #1;
      if (auto_resp) begin
        rd_valid = 1'b0;
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            rd_valid = 1'b1;
            rd_data = rd_pend;
          end
        end
        if (acc && !accwr) begin
          rd_cnt = 3;
          rd_pend = rd_model(acca);
        end
        cmd_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  initial begin
    int e0;
    vt[0] = mk(40'h55_01_12_34_A5, 5, 0, 1, 1, 16'h1234, 8'hA5);
    vt[1] = mk(40'h55_02_00_10_00, 4, 0, 1, 0, 16'h0010, 8'h00);
    vt[2] = mk(40'h00_FF_55_07_00, 4, 1, 0, 0, 16'h0000, 8'h00);
    vt[3] = mk(40'h55_01_BE_EF_00, 5, 0, 1, 1, 16'hBEEF, 8'h00);
    vt[4] = mk(40'h55_02_FF_FF_00, 4, 0, 1, 0, 16'hFFFF, 8'h00);
    vt[5] = mk(40'h55_55_00_00_00, 2, 1, 0, 0, 16'h0000, 8'h00);
    vt[6] = mk(40'h55_03_00_00_00, 2, 1, 0, 0, 16'h0000, 8'h00);
    vt[7] = mk(40'h55_02_AB_CD_00, 4, 0, 1, 0, 16'hABCD, 8'h00);

    rx_flag = 0; rx_data = 0; cmd_ready = 0;
    rd_valid = 0; rd_data = 0;
    s_rst_n = 1'b1;
    #2 s_rst_n = 1'b0;
    idle(3);
    check_zero("rst");
    s_rst_n = 1'b1;
    idle(2);

    // Write with zero-wait ready: one-cycle cmd_valid, ack next cycle
    cmd_ready = 1'b1;
    cmd_q.push_back({1'b1, 16'h1234, 8'hA5});
    tx_q.push_back(8'hAA);
    send_byte(8'h55); idle(1);
    send_byte(8'h01); idle(1);
    send_byte(8'h12); idle(1);
    send_byte(8'h34); idle(1);
    send_byte(8'hA5);
    @(negedge sclk);
    check("wr_valid_rise", cmd_valid, 1);
    @(negedge sclk);
    check("wr_valid_fall", cmd_valid, 0);
    check("wr_ack_flag", tx_flag, 1);
    check("wr_ack_data", tx_data, 8'hAA);
    idle(1);
    cmd_ready = 1'b0;
    idle(2);

    // Read with ready held low, data 10 cycles after accept
    cmd_q.push_back({1'b0, 16'h0010, 8'h00});
    send_byte(8'h55); idle(1);
    send_byte(8'h02); idle(1);
    send_byte(8'h00); idle(1);
    send_byte(8'h10);
    repeat (5) begin
      @(negedge sclk);
      check("rd_hold", cmd_valid, 1);
    end
    @(posedge sclk); #1;
    cmd_ready = 1'b1;
    @(negedge sclk);
    check("rd_hold6", cmd_valid, 1);
    @(posedge sclk); #1;
    cmd_ready = 1'b0;
    @(negedge sclk);
    check("rd_acc_fall", cmd_valid, 0);
    repeat (9) @(posedge sclk);
    #1;
    tx_q.push_back(8'h3C);
    rd_valid = 1'b1;
    rd_data = 8'h3C;
    @(posedge sclk); #1;
    rd_valid = 1'b0;
    @(negedge sclk);
    check("rd_tx_flag", tx_flag, 1);
    check("rd_tx_data", tx_data, 8'h3C);
    idle(3);

    // Frame table with the automatic responder
    auto_resp = 1;
    for (int i = 0; i < 8; i++) begin
      e0 = err_cnt;
      if (vt[i].has) begin
        cmd_q.push_back({vt[i].wr, vt[i].addr, vt[i].wd});
        tx_q.push_back(vt[i].wr ? 8'hAA : rd_model(vt[i].addr));
      end
      for (int k = 0; k < vt[i].n; k++) begin
        send_byte(vt[i].bytes[39-8*k -: 8]);
        idle(1);
      end
      wait_drain();
      idle(3);
      check("vec_err", err_cnt - e0, vt[i].errs);
    end

    // Gap timeout mid-frame
    e0 = err_cnt;
    send_byte(8'h55); idle(1);
    send_byte(8'h01); idle(1);
    send_byte(8'h12);
    idle(T);
    @(negedge sclk);
    check("to_early", err_flag, 0);
    @(negedge sclk);
    check("to_fire", err_flag, 1);
    idle(4);
    check("to_count", err_cnt - e0, 1);
    cmd_q.push_back({1'b1, 16'h5678, 8'h9A});
    tx_q.push_back(8'hAA);
    send_byte(8'h55); idle(1);
    send_byte(8'h01); idle(1);
    send_byte(8'h56); idle(1);
    send_byte(8'h78); idle(1);
    send_byte(8'h9A); idle(1);
    wait_drain();

    // Byte arriving on the expiry edge is accepted
    e0 = err_cnt;
    cmd_q.push_back({1'b1, 16'h0007, 8'h99});
    tx_q.push_back(8'hAA);
    send_byte(8'h55); idle(1);
    send_byte(8'h01);
    idle(T);
    send_byte(8'h00); idle(1);
    send_byte(8'h07); idle(1);
    send_byte(8'h99); idle(1);
    wait_drain();
    idle(2);
    check("expiry_race_err", err_cnt - e0, 0);

    // Stray byte during WAIT_RD
    auto_resp = 0;
    idle(2);
    rd_valid = 1'b0;
    cmd_ready = 1'b1;
    cmd_q.push_back({1'b0, 16'h0020, 8'h00});
    send_byte(8'h55); idle(1);
    send_byte(8'h02); idle(1);
    send_byte(8'h00); idle(1);
    send_byte(8'h20);
    idle(1);
    cmd_ready = 1'b0;
    idle(2);
    send_byte(8'h11);
    @(negedge sclk);
    check("waitrd_err", err_flag, 1);
    idle(3);
    tx_q.push_back(8'h77);
    rd_valid = 1'b1;
    rd_data = 8'h77;
    @(posedge sclk); #1;
    rd_valid = 1'b0;
    @(negedge sclk);
    check("waitrd_tx_flag", tx_flag, 1);
    check("waitrd_tx_data", tx_data, 8'h77);
    idle(3);

    // Reset while a command is pending
    send_byte(8'h55); idle(1);
    send_byte(8'h01); idle(1);
    send_byte(8'h00); idle(1);
    send_byte(8'h01); idle(1);
    send_byte(8'h02);
    @(negedge sclk);
    check("pend_valid", cmd_valid, 1);
    @(posedge sclk); #1;
    s_rst_n = 1'b0;
    #1;
    check_zero("midrst");
    idle(2);
    s_rst_n = 1'b1;
    idle(2);
    auto_resp = 1;
    cmd_q.push_back({1'b1, 16'h3344, 8'h55});
    tx_q.push_back(8'hAA);
    send_byte(8'h55); idle(1);
    send_byte(8'h01); idle(1);
    send_byte(8'h33); idle(1);
    send_byte(8'h44); idle(1);
    send_byte(8'h55); idle(1);
    wait_drain();
    idle(20);
    check("final_q", tx_q.size() + cmd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
